// File: rtl/cv32e41s_ram_arb_pkg.sv
// Shared types for the cv32e41s RAM-port arbiter: FSM states, owner tag and latched request.
// Requester-side widths here must match the arbiter's A_WID/D_WID parameters.
package cv32e41s_ram_arb_pkg;

    localparam int BE_W      = 4;
    localparam int ARB_A_WID = 32;
    localparam int ARB_D_WID = 32;

    typedef enum logic {
        IDLE = 1'b0,
        RMW  = 1'b1
    } arb_state_e;

    // Identifies which requester a RAM access or response belongs to.
    typedef logic owner_t;
    localparam owner_t OWNER_M0 = 1'b0;
    localparam owner_t OWNER_M1 = 1'b1;

    typedef struct packed {
        logic                 we;
        logic [BE_W-1:0]      be;
        logic [ARB_A_WID-1:0] addr;
        logic [ARB_D_WID-1:0] wdata;
    } arb_req_t;

endpackage

// File: rtl/cv32e41s_ram_arb_merge.sv
// Byte-lane merge for the read-modify-write path: lanes with be set take the new
// data, the rest keep the word just read from the RAM.
module cv32e41s_ram_arb_merge
    import cv32e41s_ram_arb_pkg::*;
#(
    parameter int D_WID = 32
) (
    input  logic [D_WID-1:0] old_i,
    input  logic [D_WID-1:0] new_i,
    input  logic [BE_W-1:0]  be_i,
    output logic [D_WID-1:0] word_o
);

    for (genvar i = 0; i < BE_W; i++) begin : g_lane
        assign word_o[8*i +: 8] = be_i[i] ? new_i[8*i +: 8] : old_i[8*i +: 8];
    end

endmodule

// File: rtl/cv32e41s_ram_arbiter.sv
// Two-requester OBI-style arbiter for one port of a byte-enable-less RAM; partial writes become RMW.
// Define CV32E41S_RAM_ARB_RR_EN for round-robin arbitration; otherwise m0 has fixed priority.
module cv32e41s_ram_arbiter
    import cv32e41s_ram_arb_pkg::*;
#(
    parameter int A_WID = ARB_A_WID,
    parameter int D_WID = ARB_D_WID
) (
    input  logic             clk_i,
    input  logic             rst_i,

    input  logic             m0_req_i,
    output logic             m0_gnt_o,
    input  logic             m0_we_i,
    input  logic [3:0]       m0_be_i,
    input  logic [A_WID-1:0] m0_addr_i,
    input  logic [D_WID-1:0] m0_wdata_i,
    output logic             m0_rvalid_o,
    output logic [D_WID-1:0] m0_rdata_o,

    input  logic             m1_req_i,
    output logic             m1_gnt_o,
    input  logic             m1_we_i,
    input  logic [3:0]       m1_be_i,
    input  logic [A_WID-1:0] m1_addr_i,
    input  logic [D_WID-1:0] m1_wdata_i,
    output logic             m1_rvalid_o,
    output logic [D_WID-1:0] m1_rdata_o,

    output logic             ram_en_o,
    output logic             ram_we_o,
    output logic [A_WID-1:0] ram_addr_o,
    output logic [D_WID-1:0] ram_wdata_o,
    input  logic [D_WID-1:0] ram_rdata_i
);

    localparam logic [A_WID-1:0] WORD_MASK = {{(A_WID-2){1'b1}}, 2'b00};

    arb_state_e state_q, state_d;
    arb_req_t   req_q, req_d;
    owner_t     rmw_owner_q, rmw_owner_d;
    logic       rsp_vld_q, rsp_vld_d;
    owner_t     rsp_owner_q, rsp_owner_d;
    logic       rsp_rd_q, rsp_rd_d;
`ifdef CV32E41S_RAM_ARB_RR_EN
    owner_t     rr_last_q, rr_last_d;
`endif

    logic             pick_m1;
    logic             grant;
    owner_t           winner;
    logic             sel_we;
    logic [BE_W-1:0]  sel_be;
    logic [A_WID-1:0] sel_addr;
    logic [D_WID-1:0] sel_wdata;
    logic             sel_partial;
    logic             sel_touch;
    logic [D_WID-1:0] merged;

    always_comb begin
`ifdef CV32E41S_RAM_ARB_RR_EN
        pick_m1 = m1_req_i & (~m0_req_i | (rr_last_q == OWNER_M0));
`else
        pick_m1 = m1_req_i & ~m0_req_i;
`endif
        // Grants are held off while rst_i is high so the port is quiet during reset.
        grant       = (state_q == IDLE) & (m0_req_i | m1_req_i) & ~rst_i;
        winner      = pick_m1 ? OWNER_M1 : OWNER_M0;
        sel_we      = pick_m1 ? m1_we_i    : m0_we_i;
        sel_be      = pick_m1 ? m1_be_i    : m0_be_i;
        sel_addr    = (pick_m1 ? m1_addr_i : m0_addr_i) & WORD_MASK;
        sel_wdata   = pick_m1 ? m1_wdata_i : m0_wdata_i;
        sel_partial = sel_we & (sel_be != 4'h0) & (sel_be != 4'hF);
        sel_touch   = ~sel_we | (sel_be != 4'h0);
    end

    cv32e41s_ram_arb_merge #(.D_WID(D_WID)) u_merge (
        .old_i  (ram_rdata_i),
        .new_i  (req_q.wdata),
        .be_i   (req_q.be),
        .word_o (merged)
    );

    always_comb begin
        state_d     = state_q;
        req_d       = req_q;
        rmw_owner_d = rmw_owner_q;
        rsp_vld_d   = 1'b0;
        rsp_owner_d = rsp_owner_q;
        rsp_rd_d    = 1'b0;
`ifdef CV32E41S_RAM_ARB_RR_EN
        rr_last_d   = rr_last_q;
`endif
        m0_gnt_o    = 1'b0;
        m1_gnt_o    = 1'b0;
        ram_en_o    = 1'b0;
        ram_we_o    = 1'b0;
        ram_addr_o  = '0;
        ram_wdata_o = '0;

        case (state_q)
            IDLE: begin
                if (grant) begin
                    m0_gnt_o = ~pick_m1;
                    m1_gnt_o = pick_m1;
`ifdef CV32E41S_RAM_ARB_RR_EN
                    rr_last_d = winner;
`endif
                    if (sel_partial) begin
                        // Fetch the old word now; the merged write goes out next cycle.
                        ram_en_o    = 1'b1;
                        ram_addr_o  = sel_addr;
                        req_d.we    = 1'b1;
                        req_d.be    = sel_be;
                        req_d.addr  = sel_addr;
                        req_d.wdata = sel_wdata;
                        rmw_owner_d = winner;
                        state_d     = RMW;
                    end else begin
                        ram_en_o    = sel_touch;
                        ram_we_o    = sel_touch & sel_we;
                        ram_addr_o  = sel_touch ? sel_addr : '0;
                        ram_wdata_o = sel_touch ? sel_wdata : '0;
                        rsp_vld_d   = 1'b1;
                        rsp_owner_d = winner;
                        rsp_rd_d    = ~sel_we;
                    end
                end
            end
            RMW: begin
                ram_en_o    = 1'b1;
                ram_we_o    = req_q.we;
                ram_addr_o  = req_q.addr;
                ram_wdata_o = merged;
                rsp_vld_d   = 1'b1;
                rsp_owner_d = rmw_owner_q;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            req_q       <= '0;
            rmw_owner_q <= OWNER_M0;
            rsp_vld_q   <= 1'b0;
            rsp_owner_q <= OWNER_M0;
            rsp_rd_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            req_q       <= req_d;
            rmw_owner_q <= rmw_owner_d;
            rsp_vld_q   <= rsp_vld_d;
            rsp_owner_q <= rsp_owner_d;
            rsp_rd_q    <= rsp_rd_d;
        end
    end

`ifdef CV32E41S_RAM_ARB_RR_EN
    // Reset to m1 so that m0 wins the first conflict.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rr_last_q <= OWNER_M1;
        end else begin
            rr_last_q <= rr_last_d;
        end
    end
`endif

    assign m0_rvalid_o = rsp_vld_q & (rsp_owner_q == OWNER_M0);
    assign m1_rvalid_o = rsp_vld_q & (rsp_owner_q == OWNER_M1);
    assign m0_rdata_o  = (m0_rvalid_o & rsp_rd_q) ? ram_rdata_i : '0;
    assign m1_rdata_o  = (m1_rvalid_o & rsp_rd_q) ? ram_rdata_i : '0;

endmodule

// File: tb/tb_cv32e41s_ram_arbiter.sv
// Directed bench for cv32e41s_ram_arbiter with a behavioural RAM and a response scoreboard.
// Expectations follow CV32E41S_RAM_ARB_RR_EN when defined.
module tb_cv32e41s_ram_arbiter;

    logic        clk = 1'b0;
    logic        rst_i = 1'b1;
    logic        m0_req_i, m0_gnt_o, m0_we_i, m0_rvalid_o;
    logic [3:0]  m0_be_i;
    logic [31:0] m0_addr_i, m0_wdata_i, m0_rdata_o;
    logic        m1_req_i, m1_gnt_o, m1_we_i, m1_rvalid_o;
    logic [3:0]  m1_be_i;
    logic [31:0] m1_addr_i, m1_wdata_i, m1_rdata_o;
    logic        ram_en_o, ram_we_o;
    logic [31:0] ram_addr_o, ram_wdata_o, ram_rdata;

    always #5 clk = ~clk;

    cv32e41s_ram_arbiter dut (
        .clk_i(clk), .rst_i(rst_i),
        .m0_req_i(m0_req_i), .m0_gnt_o(m0_gnt_o), .m0_we_i(m0_we_i), .m0_be_i(m0_be_i),
        .m0_addr_i(m0_addr_i), .m0_wdata_i(m0_wdata_i), .m0_rvalid_o(m0_rvalid_o), .m0_rdata_o(m0_rdata_o),
        .m1_req_i(m1_req_i), .m1_gnt_o(m1_gnt_o), .m1_we_i(m1_we_i), .m1_be_i(m1_be_i),
        .m1_addr_i(m1_addr_i), .m1_wdata_i(m1_wdata_i), .m1_rvalid_o(m1_rvalid_o), .m1_rdata_o(m1_rdata_o),
        .ram_en_o(ram_en_o), .ram_we_o(ram_we_o), .ram_addr_o(ram_addr_o),
        .ram_wdata_o(ram_wdata_o), .ram_rdata_i(ram_rdata)
    );

    // Behavioural RAM: 64 words, 1-cycle synchronous read, preloaded on the first edge.
    logic [31:0] mem [0:63];
    bit          loaded = 1'b0;
    int          ram_wr_cnt = 0;
    int          cyc = 0;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (!loaded) begin
            for (int i = 0; i < 64; i++) mem[i] <= 32'h0;
            mem[0] <= 32'hCAFE0000;
            mem[1] <= 32'hCAFE0004;
            mem[2] <= 32'hCAFE0008;
            mem[4] <= 32'hDEADBEEF;
            mem[8] <= 32'h11223344;
            loaded <= 1'b1;
        end else if (ram_en_o) begin
            if (ram_we_o) begin
                mem[ram_addr_o[7:2]] <= ram_wdata_o;
                ram_wr_cnt           <= ram_wr_cnt + 1;
            end else begin
                ram_rdata <= mem[ram_addr_o[7:2]];
            end
        end
    end

    typedef struct {
        logic [31:0] data;
        int          cyc;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    int   n_checks = 0;
    int   n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push(input logic m, input logic [31:0] d, input int lat);
        exp_t e;
        e.data = d;
        e.cyc  = cyc + lat;
        if (m) q1.push_back(e);
        else   q0.push_back(e);
    endtask

    // Monitor: pops the expected response whenever the DUT presents one.
    always @(negedge clk) begin
        exp_t e;
        check("single_rvalid", 32'(m0_rvalid_o & m1_rvalid_o), 32'h0);
        if (m0_rvalid_o) begin
            if (q0.size() == 0) check("m0_unexpected_rvalid", 32'(m0_rvalid_o), 32'h0);
            else begin
                e = q0.pop_front();
                check("m0_rdata", m0_rdata_o, e.data);
                check("m0_rsp_cycle", cyc, e.cyc);
            end
        end
        if (m1_rvalid_o) begin
            if (q1.size() == 0) check("m1_unexpected_rvalid", 32'(m1_rvalid_o), 32'h0);
            else begin
                e = q1.pop_front();
                check("m1_rdata", m1_rdata_o, e.data);
                check("m1_rsp_cycle", cyc, e.cyc);
            end
        end
        if (ram_en_o) check("ram_addr_align", 32'(ram_addr_o[1:0]), 32'h0);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drv0(input logic req, input logic we, input logic [3:0] be,
                        input logic [31:0] addr, input logic [31:0] wdata);
        m0_req_i = req; m0_we_i = we; m0_be_i = be; m0_addr_i = addr; m0_wdata_i = wdata;
    endtask

    task automatic drv1(input logic req, input logic we, input logic [3:0] be,
                        input logic [31:0] addr, input logic [31:0] wdata);
        m1_req_i = req; m1_we_i = we; m1_be_i = be; m1_addr_i = addr; m1_wdata_i = wdata;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int       wr_before;
        logic     exp_m1;
        logic [31:0] b2b_addr [3];
        logic [31:0] b2b_ram  [3];
        logic [31:0] b2b_data [3];
        b2b_addr = '{32'h0, 32'h4, 32'hA};
        b2b_ram  = '{32'h0, 32'h4, 32'h8};
        b2b_data = '{32'hCAFE0000, 32'hCAFE0004, 32'hCAFE0008};

        // Reset: requests asserted but nothing may leave the arbiter.
        drv0(1'b1, 1'b0, 4'hF, 32'h4, 32'h0);
        drv1(1'b1, 1'b1, 4'hF, 32'h8, 32'h12345678);
        tick(); tick();
        #1;
        check("rst_m0_gnt", 32'(m0_gnt_o), 32'h0);
        check("rst_m1_gnt", 32'(m1_gnt_o), 32'h0);
        check("rst_ram_en", 32'(ram_en_o), 32'h0);
        check("rst_ram_we", 32'(ram_we_o), 32'h0);
        check("rst_ram_addr", ram_addr_o, 32'h0);
        check("rst_ram_wdata", ram_wdata_o, 32'h0);
        check("rst_m0_rvalid", 32'(m0_rvalid_o), 32'h0);
        check("rst_m1_rvalid", 32'(m1_rvalid_o), 32'h0);
        check("rst_m0_rdata", m0_rdata_o, 32'h0);
        check("rst_m1_rdata", m1_rdata_o, 32'h0);
        drv0(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        drv1(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        tick();
        rst_i = 1'b0;
        tick();

        // Continuous conflict on full-word reads.
        drv0(1'b1, 1'b0, 4'hF, 32'h4, 32'h0);
        drv1(1'b1, 1'b0, 4'hF, 32'h8, 32'h0);
        for (int k = 0; k < 4; k++) begin
            #1;
`ifdef CV32E41S_RAM_ARB_RR_EN
            exp_m1 = (k % 2) == 1;
`else
            exp_m1 = 1'b0;
`endif
            check("conflict_m0_gnt", 32'(m0_gnt_o), 32'(!exp_m1));
            check("conflict_m1_gnt", 32'(m1_gnt_o), 32'(exp_m1));
            push(exp_m1, exp_m1 ? 32'hCAFE0008 : 32'hCAFE0004, 1);
            tick();
        end
        drv0(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        drv1(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        tick();

        // Single m0 read.
        drv0(1'b1, 1'b0, 4'hF, 32'h10, 32'h0);
        #1;
        check("rd_m0_gnt", 32'(m0_gnt_o), 32'h1);
        check("rd_ram_en", 32'(ram_en_o), 32'h1);
        check("rd_ram_we", 32'(ram_we_o), 32'h0);
        check("rd_ram_addr", ram_addr_o, 32'h10);
        push(1'b0, 32'hDEADBEEF, 1);
        tick();
        drv0(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        tick();

        // Partial write by m1 becomes read then merged write.
        drv1(1'b1, 1'b1, 4'b0011, 32'h20, 32'h0000ABCD);
        #1;
        check("rmw_m1_gnt", 32'(m1_gnt_o), 32'h1);
        check("rmw_rd_en", 32'(ram_en_o), 32'h1);
        check("rmw_rd_we", 32'(ram_we_o), 32'h0);
        check("rmw_rd_addr", ram_addr_o, 32'h20);
        push(1'b1, 32'h0, 2);
        tick();
        drv1(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        drv0(1'b1, 1'b0, 4'hF, 32'h0, 32'h0);
        #1;
        check("rmw_no_m0_gnt", 32'(m0_gnt_o), 32'h0);
        check("rmw_no_m1_gnt", 32'(m1_gnt_o), 32'h0);
        check("rmw_wr_en", 32'(ram_en_o), 32'h1);
        check("rmw_wr_we", 32'(ram_we_o), 32'h1);
        check("rmw_wr_addr", ram_addr_o, 32'h20);
        check("rmw_wr_data", ram_wdata_o, 32'h1122ABCD);
        tick();
        check("rmw_next_m0_gnt", 32'(m0_gnt_o), 32'h1);
        push(1'b0, 32'hCAFE0000, 1);
        tick();
        drv0(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        tick();

        // Back-to-back m0 reads, one per cycle; an unaligned address is word-aligned on the RAM side.
        for (int k = 0; k < 3; k++) begin
            drv0(1'b1, 1'b0, 4'hF, b2b_addr[k], 32'h0);
            #1;
            check("b2b_m0_gnt", 32'(m0_gnt_o), 32'h1);
            check("b2b_ram_addr", ram_addr_o, b2b_ram[k]);
            push(1'b0, b2b_data[k], 1);
            tick();
        end
        drv0(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        tick();

        // Full-word write, then an empty-byte-enable write, then read back.
        drv1(1'b1, 1'b1, 4'hF, 32'h30, 32'h55AA55AA);
        #1;
        check("fw_m1_gnt", 32'(m1_gnt_o), 32'h1);
        check("fw_ram_we", 32'(ram_we_o), 32'h1);
        check("fw_ram_wdata", ram_wdata_o, 32'h55AA55AA);
        push(1'b1, 32'h0, 1);
        tick();
        drv1(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        drv0(1'b1, 1'b1, 4'h0, 32'h30, 32'hFFFFFFFF);
        #1;
        check("be0_m0_gnt", 32'(m0_gnt_o), 32'h1);
        check("be0_ram_en", 32'(ram_en_o), 32'h0);
        push(1'b0, 32'h0, 1);
        tick();
        drv0(1'b1, 1'b0, 4'hF, 32'h30, 32'h0);
        #1;
        check("rb_m0_gnt", 32'(m0_gnt_o), 32'h1);
        push(1'b0, 32'h55AA55AA, 1);
        tick();
        drv0(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        tick(); tick();

        // Reset while in RMW: merged write and response must both vanish.
        drv0(1'b1, 1'b1, 4'b1100, 32'h20, 32'h99990000);
        #1;
        check("rstrmw_m0_gnt", 32'(m0_gnt_o), 32'h1);
        check("rstrmw_rd_we", 32'(ram_we_o), 32'h0);
        tick();
        drv0(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        wr_before = ram_wr_cnt;
        rst_i = 1'b1;
        #1;
        check("rstrmw_ram_we", 32'(ram_we_o), 32'h0);
        check("rstrmw_ram_en", 32'(ram_en_o), 32'h0);
        tick(); tick();
        rst_i = 1'b0;
        tick(); tick();
        check("rstrmw_no_write", ram_wr_cnt, wr_before);

        // First conflict after reset goes to m0; m1 keeps requesting and is served next.
        drv0(1'b1, 1'b0, 4'hF, 32'h4, 32'h0);
        drv1(1'b1, 1'b0, 4'hF, 32'h8, 32'h0);
        #1;
        check("postrst_m0_gnt", 32'(m0_gnt_o), 32'h1);
        check("postrst_m1_gnt", 32'(m1_gnt_o), 32'h0);
        push(1'b0, 32'hCAFE0004, 1);
        tick();
        drv0(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        #1;
        check("postrst_m1_served", 32'(m1_gnt_o), 32'h1);
        push(1'b1, 32'hCAFE0008, 1);
        tick();
        drv1(1'b1, 1'b0, 4'hF, 32'h20, 32'h0);
        #1;
        check("postrst_rd20_gnt", 32'(m1_gnt_o), 32'h1);
        push(1'b1, 32'h1122ABCD, 1);
        tick();
        drv1(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        tick(); tick(); tick();

        check("q0_drained", q0.size(), 32'h0);
        check("q1_drained", q1.size(), 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
